// File: rtl/tilt_direction_gen.sv
// Tilt-to-direction generator: averages accelerometer samples in blocks and emits rate-paced move strobes.
// Optional TILT_HYSTERESIS_EN adds exit hysteresis to the per-axis level classification.
module tilt_direction_gen #(
    parameter int CLK_FREQUENCY_HZ       = 100000000,
    parameter int SIMULATE               = 0,
    parameter int SIMULATE_FREQUENCY_CNT = 5,
    parameter int AVG_LOG2               = 2,
    parameter int DEADZONE               = 100,
    parameter int FAST_THRESH            = 600,
    parameter int HYST                   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [11:0] accel_x,
    input  logic signed [11:0] accel_y,
    input  logic               accel_valid,
    output logic               accel_ready,
    output logic               x_increment,
    output logic               x_decriment,
    output logic               y_increment,
    output logic               y_decriment,
    output logic [1:0]         speed,
    output logic               state_dbg
);
    // Handshake: a sample transfers on a rising edge where accel_valid && accel_ready;
    // the producer holds accel_x/accel_y stable while accel_ready is low.

    typedef enum logic {S_ACCUM = 1'b0, S_EVAL = 1'b1} state_t;

    localparam int N_SAMPLES = 1 << AVG_LOG2;
    localparam int ACC_W     = 12 + AVG_LOG2;
    localparam int CNT_SW    = AVG_LOG2 + 1;
    localparam int SLOW_TOP  = (SIMULATE != 0) ? 2 * SIMULATE_FREQUENCY_CNT - 1 : CLK_FREQUENCY_HZ / 5 - 1;
    localparam int FAST_TOP  = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT - 1 : CLK_FREQUENCY_HZ / 10 - 1;
    localparam int RATE_W    = (SLOW_TOP > 1) ? $clog2(SLOW_TOP + 1) : 1;

    state_t                    state, state_nx;
    logic                      armed;
    logic signed [ACC_W-1:0]   acc_x, acc_y;
    logic [CNT_SW-1:0]         sample_cnt;
    logic [1:0]                lvl_x, lvl_y, lvl_x_nx, lvl_y_nx, speed_nx;
    logic                      neg_x, neg_y;
    logic signed [11:0]        avg_x, avg_y;
    logic [11:0]               mag_x, mag_y;
    logic [RATE_W-1:0]         rate_cnt, rate_top;
    logic                      accept, last_sample, tick;

    function automatic logic [1:0] entry_level(input logic [11:0] mag);
        int m;
        m = int'(mag);
        if (m >= FAST_THRESH)   return 2'd2;
        else if (m >= DEADZONE) return 2'd1;
        else                    return 2'd0;
    endfunction

`ifdef TILT_HYSTERESIS_EN
    // Exits use lowered thresholds; entries use the normal ones.
    function automatic logic [1:0] hyst_level(input logic [11:0] mag, input logic [1:0] prev);
        int m;
        m = int'(mag);
        case (prev)
            2'd2: begin
                if (m < DEADZONE - HYST)         return 2'd0;
                else if (m < FAST_THRESH - HYST) return 2'd1;
                else                             return 2'd2;
            end
            2'd1: begin
                if (m >= FAST_THRESH)            return 2'd2;
                else if (m < DEADZONE - HYST)    return 2'd0;
                else                             return 2'd1;
            end
            default: return entry_level(mag);
        endcase
    endfunction
`endif

    assign accept      = accel_valid && accel_ready;
    assign last_sample = (sample_cnt == CNT_SW'(N_SAMPLES - 1));
    assign state_dbg   = (state == S_EVAL);

    assign avg_x = 12'(acc_x >>> AVG_LOG2);
    assign avg_y = 12'(acc_y >>> AVG_LOG2);
    // -2048 negates to 12'h800, which reads as 2048 unsigned.
    assign mag_x = avg_x[11] ? 12'(-avg_x) : 12'(avg_x);
    assign mag_y = avg_y[11] ? 12'(-avg_y) : 12'(avg_y);

    always_comb begin
`ifdef TILT_HYSTERESIS_EN
        lvl_x_nx = hyst_level(mag_x, lvl_x);
        lvl_y_nx = hyst_level(mag_y, lvl_y);
`else
        lvl_x_nx = entry_level(mag_x);
        lvl_y_nx = entry_level(mag_y);
`endif
        speed_nx = (lvl_x_nx > lvl_y_nx) ? lvl_x_nx : lvl_y_nx;
    end

    always_comb begin
        state_nx    = state;
        accel_ready = 1'b0;
        case (state)
            S_ACCUM: begin
                accel_ready = armed;
                if (armed && accel_valid && last_sample) state_nx = S_EVAL;
            end
            S_EVAL:  state_nx = S_ACCUM;
            default: state_nx = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_ACCUM;
            armed      <= 1'b0;
            acc_x      <= '0;
            acc_y      <= '0;
            sample_cnt <= '0;
            lvl_x      <= 2'd0;
            lvl_y      <= 2'd0;
            neg_x      <= 1'b0;
            neg_y      <= 1'b0;
            speed      <= 2'd0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            if (state == S_EVAL) begin
                lvl_x      <= lvl_x_nx;
                lvl_y      <= lvl_y_nx;
                neg_x      <= (lvl_x_nx != 2'd0) && avg_x[11];
                neg_y      <= (lvl_y_nx != 2'd0) && avg_y[11];
                speed      <= speed_nx;
                acc_x      <= '0;
                acc_y      <= '0;
                sample_cnt <= '0;
            end else if (accept) begin
                acc_x      <= acc_x + ACC_W'(accel_x);
                acc_y      <= acc_y + ACC_W'(accel_y);
                sample_cnt <= sample_cnt + CNT_SW'(1);
            end
        end
    end

    assign rate_top = (speed == 2'd2) ? RATE_W'(FAST_TOP) : RATE_W'(SLOW_TOP);
    assign tick     = (speed != 2'd0) && (rate_cnt == rate_top);

    // Restarting on a speed change keeps the first strobe a full period after the change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                       rate_cnt <= '0;
        else if ((state == S_EVAL) && (speed_nx != speed)) rate_cnt <= '0;
        else if (speed == 2'd0)                          rate_cnt <= '0;
        else if (rate_cnt == rate_top)                   rate_cnt <= '0;
        else                                             rate_cnt <= rate_cnt + RATE_W'(1);
    end

    assign x_increment = tick && (lvl_x != 2'd0) && !neg_x;
    assign x_decriment = tick && (lvl_x != 2'd0) &&  neg_x;
    assign y_increment = tick && (lvl_y != 2'd0) && !neg_y;
    assign y_decriment = tick && (lvl_y != 2'd0) &&  neg_y;

endmodule

// File: tb/tb_tilt_direction_gen.sv
// Randomized scoreboard bench for tilt_direction_gen in its short-count simulation configuration.
module tb_tilt_direction_gen;

    localparam int SLOW_PERIOD = 10;
    localparam int FAST_PERIOD = 5;
    localparam int DZ          = 100;
    localparam int FT          = 600;
    localparam int HY          = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [11:0] accel_x, accel_y;
    logic               accel_valid;
    logic               accel_ready;
    logic               x_increment, x_decriment, y_increment, y_decriment;
    logic [1:0]         speed;
    logic               state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Entry layout: {lvl_x[1:0], neg_x, lvl_y[1:0], neg_y, speed[1:0]}
    logic [7:0] exp_q[$];

    int blk_x[4];
    int blk_y[4];
    int mdl_lx = 0;
    int mdl_ly = 0;

    tilt_direction_gen #(
        .CLK_FREQUENCY_HZ(100000000), .SIMULATE(1), .SIMULATE_FREQUENCY_CNT(5),
        .AVG_LOG2(2), .DEADZONE(DZ), .FAST_THRESH(FT), .HYST(HY)
    ) dut (
        .clk(clk), .reset(reset), .accel_x(accel_x), .accel_y(accel_y),
        .accel_valid(accel_valid), .accel_ready(accel_ready),
        .x_increment(x_increment), .x_decriment(x_decriment),
        .y_increment(y_increment), .y_decriment(y_decriment),
        .speed(speed), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, straight from the rules: floor average, magnitude, thresholds.
    function automatic int floor_avg(input int sum);
        int q;
        q = sum / 4;
        if ((sum % 4 != 0) && (sum < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int level_of(input int mag, input int prev);
`ifdef TILT_HYSTERESIS_EN
        if (prev == 2) return (mag < DZ - HY) ? 0 : (mag < FT - HY) ? 1 : 2;
        if (prev == 1) return (mag >= FT) ? 2 : (mag < DZ - HY) ? 0 : 1;
`endif
        if (mag >= FT) return 2;
        if (mag >= DZ) return 1;
        return (prev < 0) ? 0 : 0;
    endfunction

    task automatic push_expect();
        int sx, sy, ax, ay, lx, ly, sp;
        sx = 0; sy = 0;
        for (int i = 0; i < 4; i++) begin
            sx += blk_x[i];
            sy += blk_y[i];
        end
        ax = floor_avg(sx);
        ay = floor_avg(sy);
        lx = level_of((ax < 0) ? -ax : ax, mdl_lx);
        ly = level_of((ay < 0) ? -ay : ay, mdl_ly);
        sp = (lx > ly) ? lx : ly;
        mdl_lx = lx;
        mdl_ly = ly;
        exp_q.push_back({2'(lx), (lx != 0) && (ax < 0), 2'(ly), (ly != 0) && (ay < 0), 2'(sp)});
    endtask

    task automatic drive_sample(input int x, input int y);
        int waited;
        accel_x     = 12'(x);
        accel_y     = 12'(y);
        accel_valid = 1'b1;
        waited      = 0;
        forever begin
            @(negedge clk);
            if (accel_ready) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_block(input int gap_max);
        int g;
        for (int i = 0; i < 4; i++) begin
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            if (g > 0) begin
                accel_valid = 1'b0;
                repeat (g) @(posedge clk);
                #1;
            end
            drive_sample(blk_x[i], blk_y[i]);
        end
        push_expect();
    endtask

    task automatic set_const(input int x, input int y);
        for (int i = 0; i < 4; i++) begin
            blk_x[i] = x;
            blk_y[i] = y;
        end
    endtask

    task automatic idle(input int n);
        accel_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_speed"}, speed, 0);
        check({tag, "_ready"}, accel_ready, 0);
        check({tag, "_strobes"}, {x_increment, x_decriment, y_increment, y_decriment}, 0);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        #1;
        check("ready_before_first_edge", accel_ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_first_edge", accel_ready, 1);
        mdl_lx = 0;
        mdl_ly = 0;
    endtask

    // Monitor: follows evaluations, pops expectations, and predicts strobe timing.
    initial begin : monitor
        logic [7:0] cur;
        logic [1:0] m_speed;
        logic [1:0] m_lx, m_ly;
        logic       m_nx, m_ny;
        logic [3:0] exp_s;
        int         phase, period, acc_cnt;
        bit         pending;
        m_speed = 0; m_lx = 0; m_ly = 0; m_nx = 0; m_ny = 0;
        phase = 0; acc_cnt = 0; pending = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_speed = 0; m_lx = 0; m_ly = 0; m_nx = 0; m_ny = 0;
                phase = 0; acc_cnt = 0; pending = 0;
                continue;
            end
            if (pending) begin
                pending = 0;
                check("ready_after_eval", accel_ready, 1);
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("speed", speed, cur[1:0]);
                    if (cur[1:0] != m_speed) phase = 0;
                    else if (m_speed != 0) phase = (phase + 1) % ((m_speed == 2) ? FAST_PERIOD : SLOW_PERIOD);
                    m_speed = cur[1:0];
                    m_lx = cur[7:6]; m_nx = cur[5];
                    m_ly = cur[4:3]; m_ny = cur[2];
                end
            end else if (m_speed != 0) begin
                phase = (phase + 1) % ((m_speed == 2) ? FAST_PERIOD : SLOW_PERIOD);
            end else begin
                phase = 0;
            end
            period = (m_speed == 2) ? FAST_PERIOD : SLOW_PERIOD;
            exp_s = 4'b0000;
            if (m_speed != 0 && phase == period - 1) begin
                exp_s[3] = (m_lx != 0) && !m_nx;
                exp_s[2] = (m_lx != 0) &&  m_nx;
                exp_s[1] = (m_ly != 0) && !m_ny;
                exp_s[0] = (m_ly != 0) &&  m_ny;
            end
            check("strobes", {x_increment, x_decriment, y_increment, y_decriment}, exp_s);
            if (accel_valid && accel_ready) acc_cnt++;
            if (state_dbg) begin
                check("ready_low_in_eval", accel_ready, 0);
                check("accepts_per_block", acc_cnt, 4);
                acc_cnt = 0;
                pending = 1;
            end
        end
    end

    initial begin : stimulus
        int tbl[12];
        int w;
        tbl = '{0, 99, 100, 599, 600, -99, -100, -599, -600, -2048, 2047, 300};
        reset = 1'b1; accel_valid = 1'b0; accel_x = '0; accel_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        #2;
        release_reset();

        set_const(300, 0);        drive_block(2); idle(35);
        set_const(-700, 700);     drive_block(2); idle(22);
        blk_x = '{90, 90, 110, 110}; blk_y = '{0, 0, 0, 0};
        drive_block(1); idle(25);
        set_const(99, 0);         drive_block(1); idle(20);

        // Back-to-back blocks with accel_valid never dropping.
        set_const(-300, 650);     drive_block(0);
        set_const(-2048, 0);      drive_block(0);
        idle(25);

        // Reset in the middle of a block.
        set_const(300, 0);        drive_block(0); idle(15);
        drive_sample(-1500, 900);
        drive_sample(-1500, 900);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        accel_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        release_reset();
        set_const(300, 0);        drive_block(1); idle(25);

        set_const(80, 0);         drive_block(1); idle(15);
        set_const(60, 0);         drive_block(1); idle(15);

        for (int b = 0; b < 14; b++) begin
            for (int i = 0; i < 4; i++) begin
                int mx, my, bx, by;
                mx = $urandom_range(0, 2);
                my = $urandom_range(0, 2);
                bx = tbl[$urandom_range(0, 11)];
                by = tbl[$urandom_range(0, 11)];
                blk_x[i] = (mx == 1) ? int'($urandom_range(0, 4095)) - 2048 : bx;
                blk_y[i] = (my == 1) ? int'($urandom_range(0, 4095)) - 2048 : by;
            end
            if ($urandom_range(0, 1) == 1) begin
                set_const(tbl[$urandom_range(0, 11)], tbl[$urandom_range(0, 11)]);
            end
            drive_block(2);
            idle($urandom_range(0, 25));
        end

        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        idle(15);
        check("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
